uart_tx_buffer: RTL and testbench
=================================

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 The block SHALL have parameter P_UART_DATA_WIDTH, default 8, giving the width of one UART data word.
REQ-002 The block SHALL have parameter P_FIFO_DEPTH, default 16, giving total word capacity; the value SHALL be a power of two and at least 4.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_wr_data, input, P_UART_DATA_WIDTH bits: the word to enqueue.
REQ-006 The block SHALL have port i_wr_en, input, 1 bit: the enqueue request, sampled each rising edge.
REQ-007 The block SHALL have port o_full, output, 1 bit: high when o_count equals P_FIFO_DEPTH.
REQ-008 The block SHALL have port o_count, output, log2(P_FIFO_DEPTH)+1 bits: the number of words held, including the output register.
REQ-009 The block SHALL have port o_overflow, output, 1 bit: a sticky flag meaning that a write was dropped.
REQ-010 The block SHALL have port o_user_tx_data, output, P_UART_DATA_WIDTH bits: the head word presented to uart_drive.
REQ-011 The block SHALL have port o_user_tx_valid, output, 1 bit: high when o_user_tx_data holds a valid word.
REQ-012 The block SHALL have port i_user_tx_ready, input, 1 bit: high when uart_drive can accept a word.

Function
REQ-013 The block SHALL be a synchronous FIFO placed upstream of uart_drive, driving its i_user_tx_data and i_user_tx_valid ports and consuming its o_user_tx_ready port.
REQ-014 A write SHALL be accepted on a rising edge when i_wr_en=1 and o_full=0, where o_full is the value before that edge.
REQ-015 A write attempted while o_full=1 SHALL be discarded, leave storage and o_count unchanged, and set o_overflow=1.
REQ-016 o_overflow SHALL remain 1 until reset.
REQ-017 A read transfer SHALL occur on a rising edge when o_user_tx_valid=1 and i_user_tx_ready=1.
REQ-018 While o_user_tx_valid=1 and i_user_tx_ready=0, o_user_tx_data SHALL be held stable.
REQ-019 o_user_tx_valid SHALL NOT drop until a read transfer occurs.
REQ-020 o_user_tx_data and o_user_tx_valid SHALL be driven directly from registers, with no combinational path from i_wr_en or i_user_tx_ready.
REQ-021 Latency: a word accepted on edge N into an empty FIFO SHALL appear with o_user_tx_valid=1 after edge N+1.
REQ-022 Throughput: with i_user_tx_ready held at 1 and data available, the block SHALL complete one read transfer per cycle with no bubbles.
REQ-023 After a read transfer, the next word (if any) SHALL be loaded into the output register on the same edge; otherwise o_user_tx_valid SHALL go to 0.
REQ-024 Order: words SHALL leave in exactly the order they were accepted.
REQ-025 Read and write pointers SHALL be log2(P_FIFO_DEPTH) bits wide and wrap modulo P_FIFO_DEPTH with no skipped or repeated slot.
REQ-026 o_count: an accepted write alone SHALL add 1, a read transfer alone SHALL subtract 1, and both on the same edge SHALL leave it unchanged.
REQ-027 o_count SHALL never exceed P_FIFO_DEPTH and never go below 0.
REQ-028 Simultaneous write and read while full: the write SHALL be dropped (overflow set), the read SHALL proceed, and o_count SHALL become P_FIFO_DEPTH-1.
REQ-029 Simultaneous write and read with o_count=1: the new word SHALL become the head on the same edge and o_user_tx_valid SHALL stay 1.
REQ-030 i_user_tx_ready toggling while o_user_tx_valid=0 SHALL have no effect.

Reset
REQ-031 While i_rst=0, pointers and o_count SHALL be 0, o_full=0, o_overflow=0, o_user_tx_valid=0, and o_user_tx_data=0, asserted asynchronously.
REQ-032 Reset asserted mid-operation SHALL discard all stored words, including the word in the output register.
REQ-033 The first write SHALL be accepted on the first rising edge after i_rst returns to 1.

Verification
REQ-034 Scenario single word: i_user_tx_ready=0, write 0xA5 on edge 1 -> o_user_tx_valid=1 with o_user_tx_data=0xA5 after edge 2 and o_count=1; the word is held until ready=1, then valid=0 and o_count=0.
REQ-035 Scenario fill and overflow: ready=0, write 0x00..0x0F then 0xFF -> o_full=1 after the 16th write, 0xFF is dropped, o_overflow=1 and o_count=16.
REQ-036 Scenario drain order: after the fill above, ready=1 -> 0x00..0x0F appear on 16 consecutive cycles, then valid=0, o_count=0 and o_overflow is still 1.
REQ-037 Scenario wrap and stream: 40 words with writes and ready=1 every cycle -> output matches input order across pointer wrap, with o_count steady at 1 or 2.
REQ-038 Scenario stall with simultaneous full: full FIFO, ready=1 and write on the same edge -> write dropped, o_count=15 and head advances by one word.
REQ-039 Scenario reset mid-stream: i_rst=0 for 2 cycles with o_count=7 -> all outputs at reset values immediately, and the next written word appears first.

Source files
------------

// File: rtl/uart_tx_buffer.sv
// Synchronous FIFO feeding uart_drive: words are buffered in a small RAM and the
// head word is presented from a dedicated output register with a valid/ready handshake.
module uart_tx_buffer #(
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_FIFO_DEPTH      = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [P_UART_DATA_WIDTH-1:0]     i_wr_data,
    input  logic                             i_wr_en,
    output logic                             o_full,
    output logic [$clog2(P_FIFO_DEPTH):0]    o_count,
    output logic                             o_overflow,
    output logic [P_UART_DATA_WIDTH-1:0]     o_user_tx_data,
    output logic                             o_user_tx_valid,
    input  logic                             i_user_tx_ready
);

    localparam int AW = $clog2(P_FIFO_DEPTH);
    localparam int CW = AW + 1;

    // The RAM never holds more than P_FIFO_DEPTH-1 words while the head register is
    // occupied, and at most one while it is empty, so wr_ptr never laps rd_ptr.
    logic [P_UART_DATA_WIDTH-1:0] mem [P_FIFO_DEPTH];
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [CW-1:0]                count;
    logic [P_UART_DATA_WIDTH-1:0] head_data;
    logic                         head_valid;
    logic                         overflow;

    logic                         full;
    logic                         mem_empty;
    logic                         wr_accept;
    logic                         rd_xfer;
    logic                         load_head;
    logic                         bypass;
    logic                         mem_wr;
    logic [CW-1:0]                count_next;

    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it unassigned and infer a latch.
        full       = 1'b0;
        mem_empty  = 1'b0;
        wr_accept  = 1'b0;
        rd_xfer    = 1'b0;
        load_head  = 1'b0;
        bypass     = 1'b0;
        mem_wr     = 1'b0;
        count_next = count;

        full      = (count == CW'(P_FIFO_DEPTH));
        // Words in RAM = total count minus the one sitting in the head register.
        mem_empty = (count == {{(CW-1){1'b0}}, head_valid});
        wr_accept = i_wr_en && !full;
        rd_xfer   = head_valid && i_user_tx_ready;

        // Refill the head from RAM when it is empty or being consumed this edge.
        load_head = (!head_valid || rd_xfer) && !mem_empty;
        // Head consumed with nothing queued behind it: the incoming word goes straight to the head.
        bypass    = rd_xfer && mem_empty && wr_accept;
        mem_wr    = wr_accept && !bypass;

        count_next = count + {{(CW-1){1'b0}}, wr_accept} - {{(CW-1){1'b0}}, rd_xfer};
    end

    // NOTE: the storage array has no reset; only pointers and count define which entries are live.
    always_ff @(posedge i_clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (mem_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load_head) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            if (i_wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            head_data  <= '0;
            head_valid <= 1'b0;
        end else begin
            if (bypass) begin
                head_data <= i_wr_data;
            end else if (load_head) begin
                head_data <= mem[rd_ptr];
            end

            if (load_head || bypass) begin
                head_valid <= 1'b1;
            end else if (rd_xfer) begin
                head_valid <= 1'b0;
            end
        end
    end

    assign o_full          = full;
    assign o_count         = count;
    assign o_overflow      = overflow;
    assign o_user_tx_data  = head_data;
    assign o_user_tx_valid = head_valid;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the FIFO's observable behaviour.
module tb_uart_tx_buffer;

    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [W-1:0]  i_wr_data;
    logic          i_wr_en;
    logic          o_full;
    logic [CW-1:0] o_count;
    logic          o_overflow;
    logic [W-1:0]  o_user_tx_data;
    logic          o_user_tx_valid;
    logic          i_user_tx_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Model: every word held (head first), whether the head is presented yet, sticky overflow.
    logic [W-1:0] q[$];
    bit           m_vis;
    bit           m_ov;

    uart_tx_buffer #(
        .P_UART_DATA_WIDTH (W),
        .P_FIFO_DEPTH      (DEPTH)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_wr_data       (i_wr_data),
        .i_wr_en         (i_wr_en),
        .o_full          (o_full),
        .o_count         (o_count),
        .o_overflow      (o_overflow),
        .o_user_tx_data  (o_user_tx_data),
        .o_user_tx_valid (o_user_tx_valid),
        .i_user_tx_ready (i_user_tx_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_vis = 1'b0;
        m_ov  = 1'b0;
    endtask

    // One rising edge of the model, using the state held before the edge.
    task automatic model_edge(input logic we, input logic [W-1:0] d, input logic rdy);
        bit rd;
        int pre;
        rd  = m_vis && rdy;
        pre = q.size();
        if (rd) void'(q.pop_front());
        if (we) begin
            if (pre == DEPTH) m_ov = 1'b1;
            else              q.push_back(d);
        end
        if (rd)          m_vis = (q.size() > 0);
        else if (!m_vis) m_vis = (pre > 0);
    endtask

    task automatic compare_all();
        check("count", 32'(o_count), q.size());
        check("full", 32'(o_full), 32'(q.size() == DEPTH));
        check("overflow", 32'(o_overflow), 32'(m_ov));
        check("valid", 32'(o_user_tx_valid), 32'(m_vis));
        if (m_vis) check("data", 32'(o_user_tx_data), 32'(q[0]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 32'(o_count), 0);
        check({tag, "_full"}, 32'(o_full), 0);
        check({tag, "_ovf"}, 32'(o_overflow), 0);
        check({tag, "_valid"}, 32'(o_user_tx_valid), 0);
        check({tag, "_data"}, 32'(o_user_tx_data), 0);
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic cycle(input logic we, input logic [W-1:0] d, input logic rdy);
        i_wr_en         = we;
        i_wr_data       = d;
        i_user_tx_ready = rdy;
        @(posedge i_clk);
        model_edge(we, d, rdy);
        #1;
        compare_all();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1);
    endtask

    initial begin
        i_rst           = 1'b0;
        i_wr_en         = 1'b0;
        i_wr_data       = '0;
        i_user_tx_ready = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rst_init");
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;

        // Single word: latency of one extra edge, held while not ready.
        cycle(1'b1, 8'hA5, 1'b0);
        check("s1_valid_edge1", 32'(o_user_tx_valid), 0);
        cycle(1'b0, 8'h00, 1'b0);
        check("s1_valid_edge2", 32'(o_user_tx_valid), 1);
        check("s1_data_edge2", 32'(o_user_tx_data), 32'hA5);
        repeat (3) cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        check("s1_valid_done", 32'(o_user_tx_valid), 0);
        check("s1_count_done", 32'(o_count), 0);

        // Fill to full, then one dropped write.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, W'(i), 1'b0);
        check("fill_full", 32'(o_full), 1);
        check("fill_ovf_clear", 32'(o_overflow), 0);
        cycle(1'b1, 8'hFF, 1'b0);
        check("fill_ovf_set", 32'(o_overflow), 1);
        check("fill_count", 32'(o_count), DEPTH);

        // Drain: one word per cycle in write order.
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 32'(o_user_tx_data), i);
            cycle(1'b0, 8'h00, 1'b1);
        end
        check("drain_valid", 32'(o_user_tx_valid), 0);
        check("drain_count", 32'(o_count), 0);
        check("drain_ovf_sticky", 32'(o_overflow), 1);

        // Full with simultaneous read and write.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, W'(8'h40 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check("stall_head", 32'(o_user_tx_data), 32'h40);
        cycle(1'b1, 8'hEE, 1'b1);
        check("stall_count", 32'(o_count), DEPTH - 1);
        check("stall_head_next", 32'(o_user_tx_data), 32'h41);
        drain();

        // Streaming across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, W'($urandom), 1'b1);
            if (i > 0) check("stream_count_1_2", 32'(o_count == 1 || o_count == 2), 1);
        end
        drain();

        // Reset mid-stream with seven words held.
        for (int i = 0; i < 7; i++) cycle(1'b1, W'(8'h70 + i), 1'b0);
        check("mid_count7", 32'(o_count), 7);
        i_wr_en = 1'b0;
        #2;
        i_rst = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rst_async");
        repeat (2) @(posedge i_clk);
        #1;
        check_reset_outputs("rst_hold");
        i_rst = 1'b1;
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b1, 8'h3D, 1'b0);
        check("post_rst_head", 32'(o_user_tx_data), 32'h3C);
        drain();

        // Randomized traffic with per-block write/ready densities.
        for (int b = 0; b < 20; b++) begin
            int p_wr;
            int p_rd;
            p_wr = $urandom_range(10, 95);
            p_rd = $urandom_range(5, 95);
            for (int i = 0; i < 100; i++) begin
                cycle(1'($urandom_range(0, 99) < p_wr), W'($urandom),
                      1'($urandom_range(0, 99) < p_rd));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
